// File: rtl/pc_stack_pkg.sv
// ============================================================================
// Module  : pc_stack_pkg
// Purpose : Operation encoding and priority decode shared by pc_stack.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_stack_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_INC  = 3'd1,
        OP_LOAD = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } pc_op_e;

    // One operation per edge: ret > call > load > inc > hold.
    function automatic pc_op_e decode_op(input logic ret, input logic call,
                                         input logic load, input logic inc);
        if (ret)       return OP_RET;
        else if (call) return OP_CALL;
        else if (load) return OP_LOAD;
        else if (inc)  return OP_INC;
        else           return OP_HOLD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_stack_lifo_mem.sv
// ============================================================================
// Module  : lifo_mem
// Purpose : WIDTH x DEPTH return-address stack with occupancy count and top.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lifo_mem #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [SPW-1:0]   sp,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SPW-1:0]   r_sp;
    logic [SPW-1:0]   w_sp_m1;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_sp == '0);
    assign full      = (r_sp == SPW'(DEPTH));
    assign sp        = r_sp;
    assign w_sp_m1   = r_sp - SPW'(1);
    assign w_wr_idx  = r_sp[AW-1:0];
    assign w_rd_idx  = w_sp_m1[AW-1:0];
    // Pop wins a simultaneous request so the array never disagrees with sp.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & ~full & ~pop;

    // Entries are never cleared; an empty stack masks them from top.
    assign top = empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp <= '0;
        end else if (w_pop_ok) begin
            r_sp <= w_sp_m1;
        end else if (w_push_ok) begin
            r_sp <= r_sp + SPW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_stack.sv
// ============================================================================
// Module  : pc_stack
// Purpose : Program counter with jump/inc control and hardware call/return stack.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_stack
    import pc_stack_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] top,
    output logic [SPW-1:0]   sp,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] r_pc;
    logic             r_overflow;
    logic             r_underflow;

    pc_op_e           w_op;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_push;
    logic             w_pop;
    logic             w_set_ovf;
    logic             w_set_udf;

    assign w_pc_inc = r_pc + WIDTH'(1);

    always_comb begin
        w_op      = decode_op(ret, call, load, inc);
        w_pc_nxt  = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_udf = 1'b0;
        case (w_op)
            OP_RET: begin
                if (empty) begin
                    w_set_udf = 1'b1;
                end else begin
                    w_pop    = 1'b1;
                    w_pc_nxt = top;
                end
            end
            OP_CALL: begin
                // A call into a full stack is suppressed entirely, PC included.
                if (full) begin
                    w_set_ovf = 1'b1;
                end else begin
                    w_push   = 1'b1;
                    w_pc_nxt = in;
                end
            end
            OP_LOAD: w_pc_nxt = in;
            OP_INC:  w_pc_nxt = w_pc_inc;
            default: w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_overflow  <= r_overflow | w_set_ovf;
            r_underflow <= r_underflow | w_set_udf;
        end
    end

    lifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .top   (top),
        .sp    (sp),
        .empty (empty),
        .full  (full)
    );

    assign out       = r_pc;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack.sv
// ============================================================================
// Module  : tb_pc_stack
// Purpose : Directed and random checks of pc_stack against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_stack;

    localparam int W    = 16;
    localparam int D    = 8;
    localparam int SPW  = $clog2(D + 1);
    localparam int MASK = (1 << W) - 1;

    logic           clk;
    logic           reset;
    logic [W-1:0]   in;
    logic           load, inc, call, ret;
    logic [W-1:0]   out, top;
    logic [SPW-1:0] sp;
    logic           empty, full, overflow, underflow;

    int n_vec;
    int n_bad;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_udf;

    pc_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .load      (load),
        .inc       (inc),
        .call      (call),
        .ret       (ret),
        .out       (out),
        .top       (top),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int exp_top;
        exp_top = (m_stk.size() == 0) ? 0 : m_stk[m_stk.size() - 1];
        chk({tag, ".out"},   int'(out),       m_pc);
        chk({tag, ".sp"},    int'(sp),        m_stk.size());
        chk({tag, ".top"},   int'(top),       exp_top);
        chk({tag, ".empty"}, int'(empty),     int'(m_stk.size() == 0));
        chk({tag, ".full"},  int'(full),      int'(m_stk.size() == D));
        chk({tag, ".ovf"},   int'(overflow),  int'(m_ovf));
        chk({tag, ".udf"},   int'(underflow), int'(m_udf));
    endtask

    function automatic void model_reset();
        m_pc  = 0;
        m_stk = {};
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    function automatic void model_step(input bit r, input bit c, input bit l,
                                       input bit i, input int din);
        if (r) begin
            if (m_stk.size() == 0) m_udf = 1'b1;
            else                   m_pc  = m_stk.pop_back();
        end else if (c) begin
            if (m_stk.size() == D) begin
                m_ovf = 1'b1;
            end else begin
                m_stk.push_back((m_pc + 1) & MASK);
                m_pc = din;
            end
        end else if (l) begin
            m_pc = din;
        end else if (i) begin
            m_pc = (m_pc + 1) & MASK;
        end
    endfunction

    // Called at posedge+1; applies one cycle of controls and checks the result.
    task automatic cycle(input string tag, input bit r, input bit c, input bit l,
                         input bit i, input int din);
        ret  = r;
        call = c;
        load = l;
        inc  = i;
        in   = W'(din);
        model_step(r, c, l, i, din);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset lands mid-cycle and must take effect before any clock edge.
    task automatic apply_reset(input string tag);
        {ret, call, load, inc} = 4'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        in    = '0;
        {ret, call, load, inc} = 4'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("por");
        reset = 1'b0;

        $monitor("%8t rst=%b r/c/l/i=%b%b%b%b in=%h | out=%h sp=%0d top=%h e=%b f=%b of=%b uf=%b",
                 $time, reset, ret, call, load, inc, in, out, sp, top, empty, full,
                 overflow, underflow);

        for (int k = 0; k < 3; k++) cycle("inc3", 0, 0, 0, 1, 0);
        apply_reset("rst_mid");

        cycle("ld10",   0, 0, 1, 0, 'h0010);
        cycle("call1",  0, 1, 0, 0, 'h0200);
        cycle("ret1",   0, 0, 0, 0, 0);
        cycle("ret1b",  1, 0, 0, 0, 0);

        apply_reset("rst_nest");
        for (int k = 0; k < D; k++) cycle("nest", 0, 1, 0, 0, 'h100 + k);
        cycle("ovf",    0, 1, 0, 0, 'h900);
        for (int k = 0; k < D; k++) cycle("unwind", 1, 0, 0, 0, 0);
        apply_reset("rst_ovf");

        cycle("ld42",   0, 0, 1, 0, 'h0042);
        cycle("udf",    1, 0, 0, 0, 0);
        cycle("udf_c",  0, 1, 0, 0, 'h0123);
        cycle("udf_r",  1, 0, 0, 0, 0);
        apply_reset("rst_udf");

        cycle("ld54",   0, 0, 1, 0, 'h0054);
        cycle("push55", 0, 1, 0, 0, 'h0777);
        cycle("allop",  1, 1, 1, 1, 'h0999);
        cycle("ld_inc", 0, 0, 1, 1, 'h0300);

        cycle("ldffff", 0, 0, 1, 0, 'hFFFF);
        cycle("incwrp", 0, 0, 0, 1, 0);
        cycle("ldffff", 0, 0, 1, 0, 'hFFFF);
        cycle("callwr", 0, 1, 0, 0, 'h0010);
        $monitoroff;

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset("rnd_rst");
            end else begin
                cycle("rnd",
                      ($urandom_range(0, 99) < 22),
                      ($urandom_range(0, 99) < 30),
                      ($urandom_range(0, 99) < 30),
                      ($urandom_range(0, 99) < 40),
                      ($urandom_range(0, 7) == 0) ? MASK : int'($urandom_range(0, MASK)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
